// File: rtl/mem_resp_pkg.sv
// Shared types for the memory-port responder: FSM states, error codes, wait counter width.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_ALIGN = 2'b01,
        ERR_RANGE = 2'b10
    } err_t;

    localparam int CNT_W = 4;

    // Misalignment is reported in preference to an out-of-range address.
    function automatic err_t decode_err(input logic [31:0] addr, input int addr_bits);
        if (addr[1:0] != 2'b00) begin
            return ERR_ALIGN;
        end
        if ((addr >> addr_bits) != 32'd0) begin
            return ERR_RANGE;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port 32-bit word array with synchronous write and registered read.
// Latency: read data valid the cycle after an edge with re=1; write commits on the edge with we=1.
// Backpressure: none; rdata holds its value whenever re=0.
module mem_word_array #(
    parameter int    DEPTH_BITS = 6,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_BITS-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_BITS];

    // Simulation-time zero fill; contents are deliberately untouched by reset.
    initial begin
        for (int i = 0; i < 2**DEPTH_BITS; i++) begin
            mem[i] = 32'd0;
        end
    end

    // Word write and registered read; the responder never asserts both on one edge.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder: one word load/store per handshake, WAIT_STATES stall, one-cycle response pulse.
// Latency: accept in cycle N -> rsp_valid in cycle N+1+WAIT_STATES; one request per WAIT_STATES+2 cycles.
// Backpressure: req_ready is low outside IDLE; requests presented then are ignored, not queued.
module mem_port_responder
    import mem_resp_pkg::*;
#(
    parameter int    ADDR_BITS   = 8,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err
);

    localparam logic [CNT_W-1:0] WAIT_LAST = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    err_t        cur_err;
    logic        access;
    logic        ld_ok_q;
    logic [31:0] arr_rdata;

    // With zero wait states the access happens on the accept edge, before the latches
    // are loaded, so the live request is used while still in IDLE.
    assign cur_write = (state == IDLE) ? req_write : wr_q;
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign cur_err   = decode_err(cur_addr, ADDR_BITS);

    // The array is touched only on the edge entering RESP; reset on that edge aborts it.
    assign access = (state_nxt == RESP) && !reset;

    // Next-state logic: IDLE -> WAIT (or RESP) -> RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cnt_nxt   = '0;
                    state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and registered handshake/response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= ERR_NONE;
            ld_ok_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
            if (access) begin
                rsp_err <= cur_err;
                ld_ok_q <= !cur_write && (cur_err == ERR_NONE);
            end
        end
    end

    // Request capture on acceptance; these hold the request for the whole WAIT period.
    always_ff @(posedge clock) begin
        if (state == IDLE && req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Stores and faulted requests report zero data; the flag and array output both hold after RESP.
    assign rsp_rdata = ld_ok_q ? arr_rdata : 32'd0;

    mem_word_array #(
        .DEPTH_BITS (ADDR_BITS - 2),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clock (clock),
        .we    (access && cur_write && (cur_err == ERR_NONE)),
        .re    (access && !cur_write && (cur_err == ERR_NONE)),
        .addr  (cur_addr[ADDR_BITS-1:2]),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_mem_port_responder.sv
// Bench for mem_port_responder: three instances (WAIT_STATES 1, 3, 0) against a word-array model.
// Latency: checks accept-to-response distance of WAIT_STATES+1 cycles per request.
// Backpressure: checks req_ready low while busy and the continuous-valid accept cadence.
module tb_mem_port_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        rv  [3];
    logic        rr  [3];
    logic        rw  [3];
    logic [31:0] ra  [3];
    logic [31:0] rwd [3];
    logic        rsv [3];
    logic [31:0] rrd [3];
    logic [1:0]  rse [3];

    int          ws [3] = '{1, 3, 0};
    logic [31:0] mdl [3][64];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clock = ~clock;

    mem_port_responder #(.ADDR_BITS(8), .WAIT_STATES(1), .INIT_FILE("")) u_dut0 (
        .clock(clock), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]), .rsp_valid(rsv[0]), .rsp_rdata(rrd[0]), .rsp_err(rse[0]));
    mem_port_responder #(.ADDR_BITS(8), .WAIT_STATES(3), .INIT_FILE("")) u_dut1 (
        .clock(clock), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]), .rsp_valid(rsv[1]), .rsp_rdata(rrd[1]), .rsp_err(rse[1]));
    mem_port_responder #(.ADDR_BITS(8), .WAIT_STATES(0), .INIT_FILE("")) u_dut2 (
        .clock(clock), .reset(reset), .req_valid(rv[2]), .req_ready(rr[2]), .req_write(rw[2]),
        .req_addr(ra[2]), .req_wdata(rwd[2]), .rsp_valid(rsv[2]), .rsp_rdata(rrd[2]), .rsp_err(rse[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction on instance i, checked against the array model.
    task automatic do_req(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        int          k;
        bit          seen;
        logic [1:0]  e;
        logic [31:0] exp_rd;
        if (addr % 4 != 0)       e = 2'b01;
        else if (addr >= 32'd256) e = 2'b10;
        else                      e = 2'b00;
        exp_rd = (!wr && e == 2'b00) ? mdl[i][addr / 4] : 32'd0;
        @(negedge clock);
        rv[i] = 1'b1; rw[i] = wr; ra[i] = addr; rwd[i] = wd;
        k = 0;
        while (!rr[i] && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("req_ready", 32'(rr[i]), 32'd1);
        @(posedge clock);
        #1;
        // Scramble the bus after acceptance; the responder must use its captured copy.
        rv[i] = 1'b0; rw[i] = 1'($urandom); ra[i] = $urandom; rwd[i] = $urandom;
        if (wr && e == 2'b00) mdl[i][addr / 4] = wd;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            @(negedge clock);
            k++;
            if (rsv[i]) seen = 1'b1;
            else        chk("busy_ready", 32'(rr[i]), 32'd0);
        end
        chk("rsp_seen", 32'(seen), 32'd1);
        chk("latency", 32'(k), 32'(ws[i] + 1));
        chk("rdata", rrd[i], exp_rd);
        chk("err", 32'(rse[i]), 32'(e));
        @(negedge clock);
        chk("pulse_end", 32'(rsv[i]), 32'd0);
        chk("ready_back", 32'(rr[i]), 32'd1);
        chk("rdata_hold", rrd[i], exp_rd);
        chk("err_hold", 32'(rse[i]), 32'(e));
    endtask

    task automatic rand_req(input int i);
        logic [31:0] a;
        int          kind;
        kind = $urandom_range(0, 9);
        if (kind < 6) begin
            a = 32'($urandom_range(0, 63)) * 4;
        end else if (kind < 8) begin
            a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
        end else begin
            a = $urandom;
            if (a < 32'd256) a = a + 32'd256;
        end
        do_req(i, 1'($urandom), a, $urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int          last;
        int          nready;
        int          nrsp;
        logic [31:0] old;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 32'd0; rwd[i] = 32'd0;
            for (int w = 0; w < 64; w++) mdl[i][w] = 32'd0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 32'(rr[i]), 32'd1);
            chk("rst_valid", 32'(rsv[i]), 32'd0);
            chk("rst_rdata", rrd[i], 32'd0);
            chk("rst_err", 32'(rse[i]), 32'd0);
        end

        // Store/load round trip, misaligned load, out-of-range store without wrap.
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_req(0, 1'b0, 32'h10, 32'h0);
        do_req(0, 1'b0, 32'h13, 32'h0);
        do_req(0, 1'b0, 32'h10, 32'h0);
        do_req(0, 1'b1, 32'hFC, 32'hA5A5_0FF0);
        do_req(0, 1'b1, 32'h100, 32'h1111_2222);
        do_req(0, 1'b0, 32'h00, 32'h0);
        do_req(0, 1'b0, 32'hFC, 32'h0);
        do_req(0, 1'b1, 32'h103, 32'h3333_4444);
        do_req(0, 1'b0, 32'h00, 32'h0);

        // Continuous valid with three wait states: accept every fifth cycle.
        do_req(1, 1'b1, 32'h04, 32'hCAFE_F00D);
        @(negedge clock);
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h04; rwd[1] = 32'd0;
        last = -1; nready = 0; nrsp = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clock);
            if (rr[1]) begin
                if (last >= 0) chk("hold_gap", 32'(c - last), 32'd5);
                last = c;
                nready++;
            end
            if (rsv[1]) begin
                nrsp++;
                chk("hold_rdata", rrd[1], mdl[1][1]);
            end
        end
        rv[1] = 1'b0;
        chk("hold_accepts", 32'(nready), 32'd4);
        chk("hold_rsps", 32'(nrsp), 32'd4);
        repeat (2) @(negedge clock);

        // Reset during WAIT drops the pending store and suppresses the response.
        old = mdl[0][8];
        @(negedge clock);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'h12345678;
        chk("abort_ready", 32'(rr[0]), 32'd1);
        @(posedge clock);
        #1 rv[0] = 1'b0; reset = 1'b1;
        @(negedge clock);
        chk("abort_wait_valid", 32'(rsv[0]), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("abort_valid", 32'(rsv[0]), 32'd0);
        chk("abort_ready_back", 32'(rr[0]), 32'd1);
        @(negedge clock);
        chk("abort_no_late_rsp", 32'(rsv[0]), 32'd0);
        do_req(0, 1'b0, 32'h20, 32'h0);
        chk("abort_old_data", rrd[0], old);

        // Zero wait states: response one cycle after accept, load sees prior store.
        do_req(2, 1'b1, 32'h40, 32'h0BAD_CAFE);
        do_req(2, 1'b0, 32'h40, 32'h0);
        do_req(2, 1'b0, 32'h42, 32'h0);

        // Randomized traffic on every instance.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 3; i++) rand_req(i);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
